// File: rtl/coh_noc_vc_input_buffer.sv
// Credit-flow-controlled input buffer with four per-VC FIFOs, round-robin
// output arbitration with a grant lock under backpressure, and per-VC credit return.
module coh_noc_vc_input_buffer #(
  parameter int FLIT_W = 64,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [1:0]           in_vc,
  input  logic [FLIT_W-1:0]    in_flit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           out_vc,
  output logic [FLIT_W-1:0]    out_flit,
  output logic [3:0]           credit_ret,
  output logic [4*CNT_W-1:0]   vc_occupancy,
  output logic                 overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [FLIT_W-1:0] mem [4][DEPTH];
  logic [PTR_W-1:0]  wr_ptr [4];
  logic [PTR_W-1:0]  rd_ptr [4];
  logic [CNT_W-1:0]  occ [4];

  logic [1:0] rr_ptr;
  logic [1:0] lock_vc;
  logic       locked;

  logic [3:0] nonempty;
  logic [3:0] enq_acc;
  logic [3:0] deq_vec;
  logic       enq_drop;
  logic [1:0] idx;
  logic [1:0] search_vc;
  logic       search_hit;
  logic [1:0] grant_vc;
  logic       deq;

  always_comb begin
    nonempty = '0;
    for (int v = 0; v < 4; v++) begin
      nonempty[v] = (occ[v] != '0);
    end
  end

  // Round-robin search starting at rr_ptr, wrapping modulo 4
  always_comb begin
    search_vc  = rr_ptr;
    search_hit = 1'b0;
    idx        = rr_ptr;
    for (int i = 0; i < 4; i++) begin
      idx = rr_ptr + 2'(i);
      if (!search_hit && nonempty[idx]) begin
        search_hit = 1'b1;
        search_vc  = idx;
      end
    end
  end

  assign grant_vc  = locked ? lock_vc : search_vc;
  assign out_valid = |nonempty;
  assign out_vc    = out_valid ? grant_vc : 2'd0;
  assign out_flit  = out_valid ? mem[grant_vc][rd_ptr[grant_vc]] : '0;
  assign deq       = out_valid && out_ready;

  // Fullness uses pre-edge occupancy, so a same-cycle pop does not make room
  always_comb begin
    enq_acc  = '0;
    enq_drop = 1'b0;
    deq_vec  = '0;
    if (in_valid) begin
      if (occ[in_vc] == CNT_W'(DEPTH)) begin
        enq_drop = 1'b1;
      end else begin
        enq_acc[in_vc] = 1'b1;
      end
    end
    if (deq) begin
      deq_vec[grant_vc] = 1'b1;
    end
  end

  always_comb begin
    vc_occupancy = '0;
    for (int v = 0; v < 4; v++) begin
      vc_occupancy[v*CNT_W +: CNT_W] = occ[v];
    end
  end

  // Flit storage carries no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (in_valid && !enq_drop) begin
      mem[in_vc][wr_ptr[in_vc]] <= in_flit;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int v = 0; v < 4; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        occ[v]    <= '0;
      end
      rr_ptr       <= 2'd0;
      lock_vc      <= 2'd0;
      locked       <= 1'b0;
      credit_ret   <= 4'b0000;
      overflow_err <= 1'b0;
    end else begin
      for (int v = 0; v < 4; v++) begin
        if (enq_acc[v]) begin
          wr_ptr[v] <= wr_ptr[v] + PTR_W'(1);
        end
        if (deq_vec[v]) begin
          rd_ptr[v] <= rd_ptr[v] + PTR_W'(1);
        end
        case ({enq_acc[v], deq_vec[v]})
          2'b10:   occ[v] <= occ[v] + CNT_W'(1);
          2'b01:   occ[v] <= occ[v] - CNT_W'(1);
          default: occ[v] <= occ[v];
        endcase
      end

      if (deq) begin
        locked <= 1'b0;
        rr_ptr <= grant_vc + 2'd1;
      end else if (out_valid) begin
        locked  <= 1'b1;
        lock_vc <= grant_vc;
      end

      credit_ret <= deq_vec;

      if (enq_drop) begin
        overflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_coh_noc_vc_input_buffer.sv
// Directed bench for coh_noc_vc_input_buffer: reset, single flit, RR order,
// grant lock, overflow, simultaneous enq/deq and mid-stream reset.
module tb_coh_noc_vc_input_buffer;

  localparam int FLIT_W = 64;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic [1:0]           in_vc;
  logic [FLIT_W-1:0]    in_flit;
  logic                 out_valid;
  logic                 out_ready;
  logic [1:0]           out_vc;
  logic [FLIT_W-1:0]    out_flit;
  logic [3:0]           credit_ret;
  logic [4*CNT_W-1:0]   vc_occupancy;
  logic                 overflow_err;

  int checks = 0;
  int errors = 0;

  coh_noc_vc_input_buffer #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_vc        (in_vc),
    .in_flit      (in_flit),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_vc       (out_vc),
    .out_flit     (out_flit),
    .credit_ret   (credit_ret),
    .vc_occupancy (vc_occupancy),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CNT_W-1:0] occ(input int v);
    return vc_occupancy[v*CNT_W +: CNT_W];
  endfunction

  // Advance past the next rising edge; outputs are sampled and inputs driven here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vc     = 2'd0;
    in_flit   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (out_valid !== 1'b0 || credit_ret !== 4'b0000 || out_vc !== 2'd0 || out_flit !== '0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d: valid=%b credit=%b vc=%0d flit=%h, want 0", c, out_valid, credit_ret, out_vc, out_flit);
      end
      checks++;
      if (vc_occupancy !== '0 || overflow_err !== 1'b0) begin
        errors++;
        $display("FAIL reset_occ cyc=%0d: occ=%h ovf=%b, want 0", c, vc_occupancy, overflow_err);
      end
      tick();
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_vc     = 2'd0;
    in_flit   = 64'hA5A5_A5A5_A5A5_A5A5;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_vc !== 2'd0 || out_flit !== 64'hA5A5_A5A5_A5A5_A5A5) begin
      errors++;
      $display("FAIL single_present: valid=%b vc=%0d flit=%h, want 1/0/a5a5..", out_valid, out_vc, out_flit);
    end
    checks++;
    if (occ(0) !== 5'd1 || credit_ret !== 4'b0000) begin
      errors++;
      $display("FAIL single_occ: occ0=%0d credit=%b, want 1/0000", occ(0), credit_ret);
    end
    tick();
    checks++;
    if (credit_ret !== 4'b0001 || out_valid !== 1'b0 || occ(0) !== 5'd0) begin
      errors++;
      $display("FAIL single_credit: credit=%b valid=%b occ0=%0d, want 0001/0/0", credit_ret, out_valid, occ(0));
    end
    tick();
    checks++;
    if (credit_ret !== 4'b0000) begin
      errors++;
      $display("FAIL single_credit_clear: credit=%b, want 0000", credit_ret);
    end
  endtask

  // Loading 3,1,2,0 under backpressure: VC3 is presented first and locks,
  // then the RR pointer rotates 0,1,2.
  task automatic test_rr_order();
    logic [1:0] load_vc  [4] = '{2'd3, 2'd1, 2'd2, 2'd0};
    logic [1:0] exp_vc   [4] = '{2'd3, 2'd0, 2'd1, 2'd2};
    logic [3:0] exp_cred [4] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_vc    = load_vc[i];
      in_flit  = 64'h3000 + 64'(load_vc[i]);
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (vc_occupancy !== {5'd1, 5'd1, 5'd1, 5'd1}) begin
      errors++;
      $display("FAIL rr_loaded_occ: occ=%h, want all ones", vc_occupancy);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_vc !== exp_vc[i] || out_flit !== 64'h3000 + 64'(exp_vc[i])) begin
        errors++;
        $display("FAIL rr_grant%0d: valid=%b vc=%0d flit=%h, want vc %0d", i, out_valid, out_vc, out_flit, exp_vc[i]);
      end
      tick();
      checks++;
      if (credit_ret !== exp_cred[i]) begin
        errors++;
        $display("FAIL rr_credit%0d: credit=%b, want %b", i, credit_ret, exp_cred[i]);
      end
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rr_empty: valid=%b, want 0", out_valid);
    end
    tick();
  endtask

  task automatic test_lock(input logic with_vc3);
    do_reset();
    in_valid = 1'b1;
    in_vc    = 2'd2;
    in_flit  = 64'h2222;
    tick();
    in_vc   = 2'd0;
    in_flit = 64'h0000_0000_0000_0F00;
    tick();
    if (with_vc3) begin
      in_vc   = 2'd3;
      in_flit = 64'h3333;
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (out_vc !== 2'd2 || out_flit !== 64'h2222 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL lock_hold%0d cyc=%0d: vc=%0d flit=%h, want 2/2222", with_vc3, c, out_vc, out_flit);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (credit_ret !== 4'b0100) begin
      errors++;
      $display("FAIL lock_credit%0d: credit=%b, want 0100", with_vc3, credit_ret);
    end
    checks++;
    if (out_vc !== (with_vc3 ? 2'd3 : 2'd0) || out_flit !== (with_vc3 ? 64'h3333 : 64'h0F00)) begin
      errors++;
      $display("FAIL lock_next%0d: vc=%0d flit=%h, want vc %0d", with_vc3, out_vc, out_flit, with_vc3 ? 3 : 0);
    end
    if (with_vc3) begin
      tick();
      checks++;
      if (out_vc !== 2'd0 || out_flit !== 64'h0F00 || credit_ret !== 4'b1000) begin
        errors++;
        $display("FAIL lock_after3: vc=%0d flit=%h credit=%b, want 0/0f00/1000", out_vc, out_flit, credit_ret);
      end
    end
    tick();
    tick();
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_vc    = 2'd2;
      in_flit  = 64'h100 + 64'(i);
      tick();
    end
    checks++;
    if (occ(2) !== 5'd16 || overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full: occ2=%0d ovf=%b, want 16/0", occ(2), overflow_err);
    end
    checks++;
    if (out_flit !== 64'h100) begin
      errors++;
      $display("FAIL ovf_head: flit=%h, want 100", out_flit);
    end
    // 17th flit arrives on the same edge as the first pop and must be dropped
    in_flit   = 64'hDEAD;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (occ(2) !== 5'd15 || overflow_err !== 1'b1 || credit_ret !== 4'b0100) begin
      errors++;
      $display("FAIL ovf_drop: occ2=%0d ovf=%b credit=%b, want 15/1/0100", occ(2), overflow_err, credit_ret);
    end
    for (int i = 1; i < DEPTH; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_vc !== 2'd2 || out_flit !== 64'h100 + 64'(i)) begin
        errors++;
        $display("FAIL ovf_drain%0d: valid=%b flit=%h, want %h", i, out_valid, out_flit, 64'h100 + 64'(i));
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || occ(2) !== 5'd0 || overflow_err !== 1'b1) begin
      errors++;
      $display("FAIL ovf_end: valid=%b occ2=%0d ovf=%b, want 0/0/1", out_valid, occ(2), overflow_err);
    end
    tick();
  endtask

  task automatic test_simul_and_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_vc    = 2'd1;
      in_flit  = 64'h200 + 64'(i);
      tick();
    end
    checks++;
    if (occ(1) !== 5'd5) begin
      errors++;
      $display("FAIL simul_load: occ1=%0d, want 5", occ(1));
    end
    in_flit   = 64'h205;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (occ(1) !== 5'd5 || out_flit !== 64'h201 || credit_ret !== 4'b0010) begin
      errors++;
      $display("FAIL simul_same: occ1=%0d flit=%h credit=%b, want 5/201/0010", occ(1), out_flit, credit_ret);
    end
    tick();
    checks++;
    if (occ(1) !== 5'd4 || out_flit !== 64'h202) begin
      errors++;
      $display("FAIL simul_next: occ1=%0d flit=%h, want 4/202", occ(1), out_flit);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || vc_occupancy !== '0 || credit_ret !== 4'b0000) begin
      errors++;
      $display("FAIL midreset: valid=%b occ=%h credit=%b, want 0/0/0000", out_valid, vc_occupancy, credit_ret);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || credit_ret !== 4'b0000 || overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL postreset: valid=%b credit=%b ovf=%b, want 0/0000/0", out_valid, credit_ret, overflow_err);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vc     = 2'd0;
    in_flit   = '0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_rr_order();
    test_lock(1'b0);
    test_lock(1'b1);
    test_overflow();
    test_simul_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
